// File: rtl/i2s_capture_if.sv
// Shared iomem bus bundle as seen by the I2S capture peripheral.
// The OR-bus convention means a slave drives ready/rdata to zero when it is not addressed.
interface i2s_capture_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/i2s_capture.sv
// I2S microphone capture: synchronises sck/ws/sd, assembles MSB-first samples
// and buffers {channel, sample} words in a FIFO drained over the iomem bus.
//
// state     | meaning
// ST_IDLE   | disarmed; waiting for enable and a ws change
// ST_SHIFT  | shifting sample bits in MSB-first
// ST_HOLD   | word complete; extra bits ignored until the next ws change
module i2s_capture #(
    parameter logic [15:0] ADDR  = 16'h7000,
    parameter int          WIDTH = 16,
    parameter int          DEPTH = 16
) (
    input  logic          ck,
    input  logic          resetn,
    i2s_capture_if.slave  iomem,
    input  logic          sck,
    input  logic          ws,
    input  logic          sd,
    output logic          irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } cap_state_t;

    // synchronisers and edge detect
    logic sck_meta_q, sck_s_q, sck_prev_q;
    logic ws_meta_q, ws_s_q, ws_prev_q;
    logic sd_meta_q, sd_s_q;
    logic sck_rise;

    // capture
    cap_state_t        state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              chan_q, chan_d;
    logic              push_req_q, push_req_d;

    // FIFO and control
    logic [WIDTH:0]    mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q;
    logic              ovf_q;
    logic              enable_q;
    logic              empty, full;
    logic              do_push, pop;

    // bus
    logic              ready_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              decoded, ack, is_rd;
    logic [7:0]        offset;
    logic              ctrl_wr, flush;
    logic [31:0]       head_word, status_word;

    assign sck_rise = sck_s_q & ~sck_prev_q;

    always_ff @(posedge ck) begin
        if (!resetn) begin
            sck_meta_q <= 1'b0;
            sck_s_q    <= 1'b0;
            sck_prev_q <= 1'b0;
            ws_meta_q  <= 1'b0;
            ws_s_q     <= 1'b0;
            ws_prev_q  <= 1'b0;
            sd_meta_q  <= 1'b0;
            sd_s_q     <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            chan_q     <= 1'b0;
            push_req_q <= 1'b0;
        end else begin
            sck_meta_q <= sck;
            sck_s_q    <= sck_meta_q;
            sck_prev_q <= sck_s_q;
            ws_meta_q  <= ws;
            ws_s_q     <= ws_meta_q;
            sd_meta_q  <= sd;
            sd_s_q     <= sd_meta_q;
            // ws history runs even while disabled so enabling never sees a stale edge
            if (sck_rise) begin
                ws_prev_q <= ws_s_q;
            end
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            chan_q     <= chan_d;
            push_req_q <= push_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        chan_d     = chan_q;
        push_req_d = 1'b0;
        if (!enable_q) begin
            state_d = ST_IDLE;
        end else if (sck_rise) begin
            if (ws_s_q != ws_prev_q) begin
                // the bit on this edge is the previous word's LSB
                state_d   = ST_SHIFT;
                bit_cnt_d = '0;
                shift_d   = '0;
                chan_d    = ws_s_q;
            end else if (state_q == ST_SHIFT) begin
                shift_d    = shift_q << 1;
                shift_d[0] = sd_s_q;
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = ST_HOLD;
                    push_req_d = 1'b1;
                end
            end
        end
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign irq   = enable_q & ~empty;

    assign decoded = iomem.iomem_valid && (iomem.iomem_addr[31:16] == ADDR);
    assign ack     = decoded && !ready_q;
    assign is_rd   = (iomem.iomem_wstrb == 4'b0000);
    assign offset  = iomem.iomem_addr[7:0];
    assign ctrl_wr = ack && !is_rd && (offset == 8'h08) && iomem.iomem_wstrb[0];
    assign flush   = ctrl_wr && iomem.iomem_wdata[1];
    assign pop     = ack && is_rd && (offset == 8'h00) && !empty;
    assign do_push = push_req_q && !flush && (!full || pop);

    always_comb begin
        head_word              = '0;
        head_word[31]          = mem_q[rptr_q][WIDTH];
        head_word[WIDTH-1:0]   = mem_q[rptr_q][WIDTH-1:0];
        status_word            = {17'b0, 7'(level_q), 5'b0, ovf_q, full, empty};
    end

    always_comb begin
        rdata_d = '0;
        if (ack && is_rd) begin
            case (offset)
                8'h00:   rdata_d = empty ? 32'h0 : head_word;
                8'h04:   rdata_d = status_word;
                8'h08:   rdata_d = {31'b0, enable_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (!resetn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            enable_q <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ready_q <= ack;
            rdata_q <= rdata_d;
            if (ctrl_wr) begin
                enable_q <= iomem.iomem_wdata[0];
            end
            // flush beats a capture push landing on the same edge
            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                level_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (push_req_q && full && !pop) begin
                    ovf_q <= 1'b1;
                end
                if (do_push) begin
                    wptr_q <= wptr_q + 1'b1;
                end
                if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                level_q <= level_q + LW'(do_push) - LW'(pop);
            end
        end
    end

    always_ff @(posedge ck) begin
        if (resetn && do_push) begin
            mem_q[wptr_q] <= {chan_q, shift_q};
        end
    end

    assign iomem.iomem_ready = ready_q;
    assign iomem.iomem_rdata = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{iomem.iomem_addr[15:8], iomem.iomem_wdata[31:2], iomem.iomem_wstrb[3:1]};

endmodule

// File: tb/tb_i2s_capture.sv
// Bench for i2s_capture: register vectors from a table, I2S streams generated
// bit by bit, and a FIFO scoreboard that predicts every DATA/STATUS read.
module tb_i2s_capture;
    localparam int DEPTH = 16;
    localparam logic [31:0] A_DATA = 32'h7000_0000;
    localparam logic [31:0] A_STAT = 32'h7000_0004;
    localparam logic [31:0] A_CTRL = 32'h7000_0008;

    logic ck, resetn, sck, ws, sd, irq;
    i2s_capture_if bus_if();

    i2s_capture #(.ADDR(16'h7000), .WIDTH(16), .DEPTH(DEPTH)) dut (
        .ck(ck), .resetn(resetn), .iomem(bus_if), .sck(sck), .ws(ws), .sd(sd), .irq(irq)
    );

    int checks = 0;
    int failures = 0;
    int rise_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tx_q[$];
    logic model_ovf = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[16];

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        int lv;
        lv = exp_q.size();
        return {17'b0, 7'(lv), 5'b0, model_ovf, 1'(lv == DEPTH), 1'(lv == 0)};
    endfunction

    task automatic model_push(input logic [31:0] v);
        if (exp_q.size() >= DEPTH) model_ovf = 1'b1;
        else exp_q.push_back(v);
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic drive_bit(input logic w, input logic d);
        ws = w;
        sd = d;
        sck = 1'b0;
        repeat (4) @(posedge ck);
        #1 sck = 1'b1;
        rise_cnt++;
        repeat (4) @(posedge ck);
        #1 sck = 1'b0;
    endtask

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        logic got;
        got = 1'b0;
        r = '0;
        bus_if.iomem_valid = 1'b1;
        bus_if.iomem_addr  = a;
        bus_if.iomem_wstrb = s;
        bus_if.iomem_wdata = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge ck);
            #1;
            if (bus_if.iomem_ready) begin
                r = bus_if.iomem_rdata;
                got = 1'b1;
                break;
            end
        end
        bus_if.iomem_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL bus_timeout: no ready for addr %08h", a);
        end
    endtask

    task automatic read_reg(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 4'b0000, 32'h0, r);
        check(nm, r, exp);
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(a, 4'b1111, d, r);
    endtask

    task automatic read_data(input string nm);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        read_reg(nm, A_DATA, e);
    endtask

    // Sends tx_q as alternating left/right Philips words, starting left.
    task automatic send_stream();
        int n;
        logic [31:0] w;
        logic ch, nch;
        n = tx_q.size();
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            w = tx_q[k];
            ch = k[0];
            nch = (k == n - 1) ? ch : ~ch;
            for (int b = 31; b >= 1; b--) drive_bit(ch, w[b]);
            drive_bit(nch, w[0]);
            model_push({ch, 15'b0, w[31:16]});
        end
        tx_q.delete();
    endtask

    initial begin
        logic [31:0] r;
        logic seen;

        resetn = 1'b0;
        sck = 1'b0;
        ws = 1'b1;
        sd = 1'b0;
        bus_if.iomem_valid = 1'b0;
        bus_if.iomem_addr  = '0;
        bus_if.iomem_wstrb = '0;
        bus_if.iomem_wdata = '0;

        vecs[0]  = '{A_STAT,        4'h0, 32'h0,         1'b1, 32'h0000_0001};
        vecs[1]  = '{A_CTRL,        4'h0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[2]  = '{A_DATA,        4'h0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[3]  = '{32'h7000_000C, 4'h0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[4]  = '{A_CTRL,        4'h1, 32'h1,         1'b0, 32'h0};
        vecs[5]  = '{A_CTRL,        4'h0, 32'h0,         1'b1, 32'h0000_0001};
        vecs[6]  = '{A_CTRL,        4'h2, 32'h0,         1'b0, 32'h0};
        vecs[7]  = '{A_CTRL,        4'h0, 32'h0,         1'b1, 32'h0000_0001};
        vecs[8]  = '{A_DATA,        4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[9]  = '{A_STAT,        4'h0, 32'h0,         1'b1, 32'h0000_0001};
        vecs[10] = '{32'h7000_0020, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[11] = '{32'h7000_0020, 4'h0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[12] = '{A_CTRL,        4'h1, 32'h2,         1'b0, 32'h0};
        vecs[13] = '{A_CTRL,        4'h0, 32'h0,         1'b1, 32'h0000_0000};
        vecs[14] = '{A_CTRL,        4'h1, 32'h1,         1'b0, 32'h0};
        vecs[15] = '{A_CTRL,        4'h0, 32'h0,         1'b1, 32'h0000_0001};

        repeat (4) @(posedge ck);
        #1 resetn = 1'b1;
        check("irq_after_reset", {31'b0, irq}, 32'h0);

        // register map vectors
        for (int i = 0; i < 16; i++) begin
            bus(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, r);
            if (vecs[i].chk) check($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        check("irq_enabled_empty", {31'b0, irq}, 32'h0);

        // one stereo frame
        tx_q.push_back(32'hA5C3_5A5A);
        tx_q.push_back(32'h1234_ABCD);
        send_stream();
        repeat (4) @(posedge ck);
        #1;
        read_reg("frame_status", A_STAT, status_exp());
        check("frame_level_const", status_exp(), 32'h0000_0200);
        check("irq_not_empty", {31'b0, irq}, 32'h1);
        write_reg(A_DATA, 32'hFFFF_FFFF);
        read_reg("data_write_ignored", A_STAT, status_exp());
        read_data("frame_left");
        read_data("frame_right");
        read_data("frame_empty_read");
        read_reg("frame_status_empty", A_STAT, 32'h0000_0001);
        check("irq_drained", {31'b0, irq}, 32'h0);

        // enable mid-frame, 10 bits into a left word
        write_reg(A_CTRL, 32'h0);
        drive_bit(1'b0, 1'b0);
        for (int b = 31; b >= 22; b--) drive_bit(1'b0, 1'b1);
        write_reg(A_CTRL, 32'h1);
        for (int b = 21; b >= 1; b--) drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        begin
            logic [31:0] w;
            w = 32'h6E3B_0F0F;
            for (int b = 31; b >= 0; b--) drive_bit(1'b1, w[b]);
            model_push({1'b1, 15'b0, w[31:16]});
        end
        repeat (4) @(posedge ck);
        #1;
        read_reg("midframe_status", A_STAT, status_exp());
        read_data("midframe_first");
        read_reg("midframe_empty", A_STAT, 32'h0000_0001);

        // overflow: DEPTH+3 samples with no reads
        for (int k = 0; k < DEPTH + 3; k++) tx_q.push_back({16'(16'h1111 * (k + 1)), 16'hBEEF});
        send_stream();
        repeat (4) @(posedge ck);
        #1;
        read_reg("ovf_status", A_STAT, status_exp());
        check("ovf_status_const", status_exp(), 32'h0000_1006);
        for (int k = 0; k < DEPTH; k++) read_data($sformatf("ovf_data%0d", k));
        read_reg("ovf_sticky", A_STAT, status_exp());
        write_reg(A_CTRL, 32'h3);
        model_clear();
        read_reg("flush_status", A_STAT, 32'h0000_0001);
        read_reg("flush_ctrl", A_CTRL, 32'h0000_0001);

        // pop and push on the same edge while full
        for (int k = 0; k < DEPTH; k++) tx_q.push_back({16'(16'h0F00 + k), 16'h0000});
        send_stream();
        repeat (4) @(posedge ck);
        #1;
        read_reg("full_status", A_STAT, 32'h0000_1002);
        tx_q.push_back(32'h7777_0000);
        rise_cnt = 0;
        seen = 1'b0;
        fork
            send_stream();
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(posedge ck);
                    if (rise_cnt >= 19) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) begin
                    repeat (2) @(posedge ck);
                    #1;
                    read_data("simul_pop");
                end
            end
        join
        check("simul_sync_seen", {31'b0, seen}, 32'h1);
        repeat (4) @(posedge ck);
        #1;
        read_reg("simul_status", A_STAT, status_exp());
        check("simul_status_const", status_exp(), 32'h0000_1002);
        for (int k = 0; k < DEPTH; k++) read_data($sformatf("simul_data%0d", k));
        read_reg("simul_drained", A_STAT, 32'h0000_0001);

        // another peripheral's address
        bus_if.iomem_valid = 1'b1;
        bus_if.iomem_addr  = 32'h6000_0000;
        bus_if.iomem_wstrb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge ck);
            #1;
            check($sformatf("foreign_ready%0d", i), {31'b0, bus_if.iomem_ready}, 32'h0);
            check($sformatf("foreign_rdata%0d", i), bus_if.iomem_rdata, 32'h0);
        end
        bus_if.iomem_addr  = 32'h6000_0008;
        bus_if.iomem_wstrb = 4'hF;
        bus_if.iomem_wdata = 32'h0;
        repeat (3) @(posedge ck);
        #1;
        check("foreign_write_ready", {31'b0, bus_if.iomem_ready}, 32'h0);
        bus_if.iomem_valid = 1'b0;
        read_reg("foreign_ctrl_kept", A_CTRL, 32'h0000_0001);

        // reset during bit 7 of a left word
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        for (int b = 0; b < 6; b++) drive_bit(1'b0, 1'b1);
        resetn = 1'b0;
        drive_bit(1'b0, 1'b1);
        resetn = 1'b1;
        for (int b = 0; b < 25; b++) drive_bit(1'b0, 1'b1);
        model_clear();
        repeat (4) @(posedge ck);
        #1;
        read_reg("rst_status", A_STAT, 32'h0000_0001);
        read_reg("rst_ctrl", A_CTRL, 32'h0000_0000);
        read_reg("rst_data", A_DATA, 32'h0000_0000);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // capture after reset
        write_reg(A_CTRL, 32'h1);
        tx_q.push_back(32'hCAFE_0001);
        tx_q.push_back(32'h0BAD_F00D);
        send_stream();
        repeat (4) @(posedge ck);
        #1;
        read_reg("post_rst_status", A_STAT, status_exp());
        read_data("post_rst_left");
        read_data("post_rst_right");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_capture.md
Name: i2s_capture

Overview:
- I2S microphone capture stage that sits directly upstream of the audio engine.
- Samples one serial data line using the engine's own i2s_sck / i2s_ws as bit and frame clocks.
- Assembles MSB-first left/right samples and buffers them in a FIFO.
- Exposes the FIFO as a peripheral on the shared iomem bus, which the CPU or engine firmware drains.
- Follows the OR-bus convention: iomem_ready and iomem_rdata are zero whenever this block is not addressed.

Parameters:
- ADDR, 16'h7000, iomem_addr[31:16] match value for this peripheral.
- WIDTH, 16, captured sample bits per channel (1..24).
- DEPTH, 16, FIFO entries; power of two, 2..64.

Ports:
- ck  in  1  system clock (single clock domain).
- resetn  in  1  synchronous, active-low reset.
- iomem_valid  in  1  bus request valid.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_wstrb  in  4  byte write strobes; 0 = read.
- iomem_addr  in  32  bus address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data; 0 when not acknowledging.
- sck  in  1  I2S bit clock, asynchronous to ck.
- ws  in  1  I2S word select: 0 = left, 1 = right.
- sd  in  1  I2S serial data.
- irq  out  1  high when enable=1 and FIFO not empty.

Behaviour:
- Reset (resetn low at a ck edge): FIFO pointers/level 0, overflow 0, enable 0, capture disarmed, iomem_ready 0, iomem_rdata 0, irq 0. Applies mid-transfer; a partial sample is discarded.
- Synchroniser: sck, ws and sd each pass through 2 flops; rising edge detected on synced sck. Total: a sample is taken 3 ck after the pin edge.
- Clock ratio: ck must be at least 4x sck.
- Capture (Philips I2S):
  - At each detected sck rise, the block takes sd_s and ws_s.
  - If ws_s differs from the ws taken at the previous rise: bit_cnt <= 0, armed <= 1, chan <= ws_s. The sd bit of this edge is ignored, since it is the previous word's LSB.
  - Else, if armed and bit_cnt < WIDTH: shift sd_s in MSB-first and increment bit_cnt.
  - When bit_cnt reaches WIDTH: push {chan, sample} on the next ck.
  - Bits after WIDTH are ignored until the next ws change.
  - After enable rises, nothing is captured until the first ws change, so no partial words are stored.
  - enable=0 disarms capture; FIFO contents are retained.
- FIFO word format: bit31 = channel, bits[WIDTH-1:0] = sample, all other bits 0.
- Full: a push while full with no pop in the same cycle is dropped (newest lost) and sets sticky overflow.
- Simultaneous push and pop: both happen, including when full or when empty. When empty, the pop is a no-op, so the push simply lands.
- Register map (offset = iomem_addr[7:0]; the block decodes only iomem_addr[31:16] == ADDR):
  - 0x00 DATA, read only. Returns the head entry and pops it. Reading when empty returns 0 and changes nothing. Writes are acknowledged and ignored.
  - 0x04 STATUS, read only. bit0 empty, bit1 full, bit2 overflow, bits[14:8] level (0..DEPTH).
  - 0x08 CTRL, read/write. bit0 enable. Writing bit1=1 flushes the FIFO and clears overflow; bit1 self-clears and reads 0. Writes take effect when wstrb[0]=1.
  - Other offsets: read 0, writes ignored, still acknowledged.
- Bus handshake:
  - On a decoded valid with ready low, ready is driven high for exactly one cycle at the next edge. rdata is valid in that same cycle and 0 otherwise.
  - The pop or register write commits on the same edge that raises ready.
  - valid must drop or change address after ready; the block never double-acknowledges. ready falls the following cycle even if valid is still high.
- Flush in the same cycle as a capture push: flush wins, and the FIFO ends empty.
- irq is combinational from registered state: enable & !empty.

Test Plan:
- Reset, then read STATUS at 0x7000_0004 -> 0x0000_0001; read CTRL -> 0; irq 0.
- Enable, then drive sck=ck/8 with 32-bit slots: left 0xA5C3_xxxx, right 0x1234_xxxx -> STATUS level 2; DATA reads 0x0000_A5C3 then 0x8000_1234; third read returns 0 and STATUS reads empty.
- Enable mid-frame (ws already low, 10 bits into a word) -> no entry until the first ws change; the first stored word is the complete following channel.
- Push DEPTH+3 samples with no reads -> level 16, full=1, overflow=1; the reads return the first 16 samples in order. Write CTRL=0x3 -> STATUS 0x0000_0001 with enable still 1.
- Hold a read of DATA so that the push of a new sample lands on the same edge while the FIFO is full -> pop and push both occur, level stays 16, overflow is unchanged.
- Access 0x6000_0000 (another peripheral) -> iomem_ready and iomem_rdata stay 0. Assert resetn low during bit 7 of a word -> that word is never stored, and all registers read their reset values.
